// File: rtl/parity_stream_gen_chk_if.sv
// Word stream in, frame parity result out, for parity_stream_gen_chk.
// The master side is the data source plus the result consumer; the block itself is the slave.
interface parity_stream_gen_chk_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             mode;
  logic             odd_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic             out_error;
  logic [CNT_W-1:0] err_count;

  modport master (
    output mode, odd_sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_parity, out_error, err_count
  );

  modport slave (
    input  mode, odd_sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_parity, out_error, err_count
  );
endinterface

// File: rtl/parity_stream_gen_chk.sv
// Streaming frame parity generator/checker: XORs FRAME_LEN words together, then either emits
// the parity bit or compares it with a trailing parity beat and counts errored frames.
module parity_stream_gen_chk #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  parity_stream_gen_chk_if.slave  bus
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0]    LAST_BEAT = BW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ACCUM = 2'd0, PARB = 2'd1, RESULT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             mode_q, mode_d;
  logic             odd_q, odd_d;
  logic             par_q, par_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  function automatic logic word_xor(input logic [WIDTH-1:0] d);
    word_xor = ^d;
  endfunction

  function automatic logic frame_par(input logic acc, input logic odd);
    frame_par = odd ? ~acc : acc;
  endfunction

  // Next state, datapath and registered-output values
  always_comb begin
    logic first_s;
    logic mode_eff_s;
    logic odd_eff_s;
    logic acc_next_s;

    state_d  = state_q;
    acc_d    = acc_q;
    beat_d   = beat_q;
    mode_d   = mode_q;
    odd_d    = odd_q;
    par_d    = par_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    // Word 0 decides the frame's mode, so it must be honoured even when it is also the last word.
    first_s    = (beat_q == {BW{1'b0}});
    mode_eff_s = first_s ? bus.mode : mode_q;
    odd_eff_s  = first_s ? bus.odd_sel : odd_q;
    acc_next_s = acc_q ^ word_xor(bus.in_data);

    case (state_q)
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d  = acc_next_s;
          mode_d = mode_eff_s;
          odd_d  = odd_eff_s;
          if (beat_q == LAST_BEAT) begin
            beat_d = {BW{1'b0}};
            if (mode_eff_s) begin
              state_d = PARB;
            end else begin
              state_d = RESULT;
              par_d   = frame_par(acc_next_s, odd_eff_s);
              err_d   = 1'b0;
            end
          end else begin
            beat_d = beat_q + BW'(1'b1);
          end
        end else begin
          state_d = ACCUM;
        end
      end
      PARB: begin
        if (bus.in_valid) begin
          state_d = RESULT;
          par_d   = frame_par(acc_q, odd_q);
          err_d   = mode_q & (bus.in_data[0] != frame_par(acc_q, odd_q));
        end else begin
          state_d = PARB;
        end
      end
      RESULT: begin
        if (bus.out_ready) begin
          if (err_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end else begin
            cnt_d = cnt_q;
          end
          state_d = ACCUM;
          acc_d   = 1'b0;
          beat_d  = {BW{1'b0}};
          par_d   = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = ACCUM;
        acc_d   = 1'b0;
        beat_d  = {BW{1'b0}};
      end
    endcase

    in_ready_d  = (state_d != RESULT);
    out_valid_d = (state_d == RESULT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= 1'b0;
      beat_q      <= {BW{1'b0}};
      mode_q      <= 1'b0;
      odd_q       <= 1'b0;
      par_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beat_q      <= beat_d;
      mode_q      <= mode_d;
      odd_q       <= odd_d;
      par_q       <= par_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_parity = par_q;
  assign bus.out_error  = err_q;
  assign bus.err_count  = cnt_q;

endmodule
